// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage: dmem/BIOS/IO access, UART handshake, MEM/WB register.
// Optional statistics counters at IO 0x10/0x14/0x18 enabled by defining MEM_STAT_CTR_EN.
module mem_stage #(
  parameter int          CLK_CTR_WIDTH = 32,
  parameter logic [31:0] RESET_PC4     = 32'h4000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_fpu,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_rs2,
  input  logic [31:0] mem_inst,
  input  logic        flush,
  output logic [13:0] dmem_addr,
  output logic [31:0] dmem_din,
  output logic [3:0]  dmem_we,
  output logic [11:0] bios_addr,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ready,
  output logic        stall,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_fpu,
  output logic [31:0] wb_pc4,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_io_dout
);

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  region;
  logic [27:0] io_off;
  logic        live, is_store, is_load, in_dmem, in_io, tx_store;
  logic [3:0]  store_mask;
  logic [31:0] io_rdata;
  logic        unused_inst_bits;

  assign opcode = mem_inst[6:0];
  assign funct3 = mem_inst[14:12];
  assign region = mem_alu[31:28];
  assign io_off = mem_alu[27:0];
  assign unused_inst_bits = ^{mem_inst[31:15], mem_inst[11:7]};

  // Reset and flush both kill every side effect of the instruction in MEM.
  assign live     = (mem_inst != 32'h0) && !flush && !rst;
  assign is_store = live && (opcode == OP_STORE);
  assign is_load  = live && (opcode == OP_LOAD);
  assign in_dmem  = (region[3:2] == 2'b00) && region[0];
  assign in_io    = (region == 4'b1000);
  assign tx_store = is_store && in_io && (io_off == 28'h8);

  assign stall         = tx_store && !uart_tx_ready;
  assign uart_tx_valid = tx_store && uart_tx_ready;
  assign uart_tx_data  = mem_rs2[7:0];
  assign uart_rx_ready = is_load && in_io && (io_off == 28'h4) && uart_rx_valid;

  assign dmem_addr = mem_alu[15:2];
  assign bios_addr = mem_alu[13:2];

  always_comb begin
    store_mask = 4'b0000;
    dmem_din   = mem_rs2;
    case (funct3)
      3'b000: begin
        store_mask = 4'b0001 << mem_alu[1:0];
        dmem_din   = {4{mem_rs2[7:0]}};
      end
      3'b001: begin
        store_mask = mem_alu[0] ? 4'b0000 : (4'b0011 << {mem_alu[1], 1'b0});
        dmem_din   = {2{mem_rs2[15:0]}};
      end
      3'b010:  store_mask = (mem_alu[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
      default: store_mask = 4'b0000;
    endcase
    dmem_we = (is_store && in_dmem && !stall) ? store_mask : 4'b0000;
  end

`ifdef MEM_STAT_CTR_EN
  logic [CLK_CTR_WIDTH-1:0] cycle_ctr, inst_ctr;
  logic clr_ctrs, retire;

  assign clr_ctrs = is_store && in_io && (io_off == 28'h18);
  assign retire   = live && !stall;

  // A clear write takes priority over this cycle's increments.
  always_ff @(posedge clk) begin
    if (rst || clr_ctrs) begin
      cycle_ctr <= '0;
      inst_ctr  <= '0;
    end else begin
      cycle_ctr <= cycle_ctr + 1'b1;
      inst_ctr  <= inst_ctr + {{(CLK_CTR_WIDTH-1){1'b0}}, retire};
    end
  end
`endif

  always_comb begin
    io_rdata = 32'h0;
    case (io_off)
      28'h00: io_rdata = {30'h0, uart_rx_valid, uart_tx_ready};
      28'h04: io_rdata = {24'h0, uart_rx_data};
`ifdef MEM_STAT_CTR_EN
      28'h10: io_rdata = 32'(cycle_ctr);
      28'h14: io_rdata = 32'(inst_ctr);
`endif
      default: io_rdata = 32'h0;
    endcase
    if (!in_io) io_rdata = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_alu     <= 32'h0;
      wb_fpu     <= 32'h0;
      wb_pc4     <= RESET_PC4;
      wb_inst    <= 32'h0;
      wb_io_dout <= 32'h0;
    end else if (flush || stall) begin
      wb_alu     <= 32'h0;
      wb_fpu     <= 32'h0;
      wb_pc4     <= 32'h0;
      wb_inst    <= 32'h0;
      wb_io_dout <= 32'h0;
    end else begin
      wb_alu     <= mem_alu;
      wb_fpu     <= mem_fpu;
      wb_pc4     <= mem_pc4;
      wb_inst    <= mem_inst;
      wb_io_dout <= io_rdata;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V core, directly upstream of writeback.
- Drives dmem/BIOS/IO accesses from the EX-stage ALU result: address decode, store byte-enable and data alignment, memory-mapped UART handshake and statistics counters.
- Holds the MEM/WB pipeline register that supplies wb_alu, wb_fpu, wb_pc4, wb_inst and wb_io_dout to writeback.
- dmem and BIOS are synchronous-read RAMs; their dout arrives at writeback one cycle after the address is presented here.

Parameters:
- CLK_CTR_WIDTH, 32, width of the cycle and retired-instruction counters.
- RESET_PC4, 32'h4000_0004, value loaded into wb_pc4 on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_alu  in  32  EX-stage ALU result (address or data).
- mem_fpu  in  32  EX-stage FPU result.
- mem_pc4  in  32  PC+4 of the instruction in MEM.
- mem_rs2  in  32  store data, already forwarded.
- mem_inst  in  32  instruction in MEM; 32'h0 is a bubble.
- flush  in  1  kill the instruction in MEM (branch mispredict).
- dmem_addr  out  14  word address, mem_alu[15:2].
- dmem_din  out  32  store data shifted to its byte lane.
- dmem_we  out  4  byte write enables.
- bios_addr  out  12  word address, mem_alu[13:2].
- uart_tx_valid  out  1  transmit byte valid.
- uart_tx_data  out  8  transmit byte.
- uart_tx_ready  in  1  UART can accept a byte.
- uart_rx_valid  in  1  received byte available.
- uart_rx_data  in  8  received byte.
- uart_rx_ready  out  1  pop received byte.
- stall  out  1  freeze IF/ID/EX this cycle.
- wb_alu, wb_fpu, wb_pc4, wb_inst, wb_io_dout  out  32 each  MEM/WB register outputs.

Behaviour:
- Address decode on mem_alu[31:28]:
  - 4'b00x1: dmem.
  - 4'b0100: BIOS (read only).
  - 4'b1000: IO.
  - anything else: no side effects.
- Stores (opcode STORE, not flushed, not a bubble):
  - SB: dmem_we = 4'b0001 << alu[1:0]; data replicated across byte lanes.
  - SH: dmem_we = 4'b0011 << {alu[1],1'b0}; data replicated across halfword lanes.
  - SW: dmem_we = 4'b1111.
  - Misaligned SH/SW: dmem_we = 0, the store is dropped silently.
  - dmem_we = 0 whenever the region is not dmem, or when flush or stall is high.
- IO map (word offset):
  - 0x00 read: {30'b0, rx_valid, tx_ready}.
  - 0x04 read: {24'b0, rx_data}; a load here pulses uart_rx_ready for 1 cycle when rx_valid is high.
  - 0x08 write: tx byte.
  - 0x10 read: cycle counter.
  - 0x14 read: retired-instruction counter.
  - 0x18 write (any data): both counters cleared.
  - Unmapped IO reads return 0.
- wb_io_dout is registered so it aligns with the one-cycle RAM read latency.
- UART tx handshake:
  - A store to 0x08 with uart_tx_ready high: uart_tx_valid = 1 and uart_tx_data = rs2[7:0] in that same cycle (combinational). A single transfer occurs.
  - A store to 0x08 with uart_tx_ready low: stall = 1, MEM holds its instruction, and the WB register loads a bubble (wb_inst = 0, all other wb_* = 0). This repeats each cycle until ready.
  - No other stall source exists.
- MEM/WB register: on each rising edge, if rst, else if flush or stall, else load.
  - rst: wb_alu/fpu/inst/io_dout = 0, wb_pc4 = RESET_PC4.
  - flush or stall: load a bubble.
  - otherwise: load the mem_* values.
  - flush has priority over stall. A flush during a tx stall cancels the store, and stall drops the same cycle.
- Counters (CLK_CTR_WIDTH bits, wrap modulo 2^N, reset to 0):
  - cycle counter increments every cycle out of reset.
  - instruction counter increments when a non-bubble, non-flushed, non-stalled instruction loads into WB.
  - A clear write in the same cycle wins over the increment; the counter reads 0 next cycle.
  - Reads return the pre-edge value.
- Reset mid-operation: a pending tx stall is abandoned and uart_tx_valid goes low combinationally. Outputs reach reset values on the next edge.

Optional Feature:
- MEM_STAT_CTR_EN defined: counters and offsets 0x10/0x14/0x18 implemented as above.
- Undefined: no counter flops; reads of 0x10/0x14 return 0; writes to 0x18 are ignored.

Test Plan:
- SB to 0x1000_0003 with rs2 = 0xAABBCCDD -> dmem_we = 4'b1000, dmem_din = 0xDDDDDDDD, dmem_addr = 0x0000; next cycle wb_inst equals the store.
- SW to 0x1000_0002 -> dmem_we = 0, no stall, instruction still retires (instruction counter +1).
- Store 0x41 to 0x8000_0008 with tx_ready low for 3 cycles, then high -> stall high 3 cycles, 3 bubbles in WB, uart_tx_valid with data 0x41 pulses exactly once.
- Load 0x8000_0004 with rx_valid = 1, rx_data = 0x5A -> uart_rx_ready pulses 1 cycle; next cycle wb_io_dout = 0x0000005A.
- Flush during SW to dmem, and separately during a tx stall -> dmem_we = 0, WB gets a bubble, stall deasserts the same cycle.
- (MEM_STAT_CTR_EN) reset, run 10 cycles retiring 4 instructions, load 0x14 -> 4; store to 0x18 then load 0x10 -> value equals the cycles elapsed since the clear; rst asserted -> wb_pc4 = 0x4000_0004 and both counters = 0.
